// File: rtl/hack_cpu_core.sv
// rtl/hack_cpu_core.sv - Hack CPU control core: A/D/PC registers, decode, jump and write control
module hack_cpu_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [15:0] instruction,
    input  logic [15:0] inM,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic        alu_zx,
    output logic        alu_nx,
    output logic        alu_zy,
    output logic        alu_ny,
    output logic        alu_f,
    output logic        alu_no,
    output logic [15:0] outM,
    output logic        writeM,
    output logic [14:0] addressM,
    output logic [14:0] pc
);

    // Architectural state
    logic [15:0] a_q, a_d;
    logic [15:0] d_q, d_d;
    logic [14:0] pc_q, pc_d;

    // Decoded instruction fields
    logic        is_c;
    logic        a_bit;
    logic        dest_a, dest_d, dest_m;
    logic        j_lt, j_eq, j_gt;
    logic        take;
    logic        unused_bits;

    assign is_c   = instruction[15];
    assign a_bit  = instruction[12];
    assign dest_a = instruction[5];
    assign dest_d = instruction[4];
    assign dest_m = instruction[3];
    assign j_lt   = instruction[2];
    assign j_eq   = instruction[1];
    assign j_gt   = instruction[0];

    // Bits [14:13] of a C-instruction carry no meaning
    assign unused_bits = ^instruction[14:13];

    // Jump condition evaluated from the flags of the ALU result computed this cycle
    assign take = is_c & ((j_lt & alu_ng) | (j_eq & alu_zr) | (j_gt & ~alu_ng & ~alu_zr));

    // ALU operand and control drive; purely combinational so the ALU settles even while stalled
    assign alu_x  = d_q;
    assign alu_y  = a_bit ? inM : a_q;
    assign alu_zx = instruction[11];
    assign alu_nx = instruction[10];
    assign alu_zy = instruction[9];
    assign alu_ny = instruction[8];
    assign alu_f  = instruction[7];
    assign alu_no = instruction[6];

    // Memory side: address is the old A, so dest=AM writes to the pre-update address
    assign outM     = alu_out;
    assign addressM = a_q[14:0];
    assign writeM   = is_c & dest_m & ~stall & ~reset;
    assign pc       = pc_q;

    // Next-state selection for A, D and PC; stall freezes everything
    always_comb begin
        a_d  = a_q;
        d_d  = d_q;
        pc_d = pc_q + 15'd1;
        if (stall) begin
            pc_d = pc_q;
        end else if (!is_c) begin
            a_d = instruction;
        end else begin
            if (dest_a) a_d = alu_out;
            if (dest_d) d_d = alu_out;
            if (take)   pc_d = a_q[14:0];
        end
    end

    // State registers with synchronous active-high reset that overrides stall
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q  <= 16'h0000;
            d_q  <= 16'h0000;
            pc_q <= 15'h0000;
        end else begin
            a_q  <= a_d;
            d_q  <= d_d;
            pc_q <= pc_d;
        end
    end

endmodule
